// File: rtl/bus_responder.sv
// bus_responder
//   Responder end of the processor memory bus. It decodes Adr and serves a
//   64x32 word RAM plus a small block of memory-mapped registers: an LED
//   register, a free-running cycle counter and a reloadable down-counting
//   timer.
//
// Ports
//   clk        in   1  system clock, all state updates on the rising edge
//   reset      in   1  synchronous active-high reset
//   MemWrite   in   1  write strobe for the current cycle
//   Adr        in  32  byte address (Adr[1:0] ignored, word access only)
//   WriteData  in  32  store data, valid with MemWrite
//   ReadData   out 32  combinational load data
//   LedOut     out  8  LED register
//   TimerFlag  out  1  sticky timer-expired status (EXP)
//
// Map (Adr[31:9] must be 0, otherwise unmapped)
//   0x000-0x0FF RAM | 0x100 LED | 0x104 CYCLE | 0x108 LOAD
//   0x10C CTRL {EXP,AR,EN} | 0x110 VAL | 0x114-0x1FF unmapped
module bus_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  LedOut,
    output logic        TimerFlag
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } timer_state_t;

    timer_state_t r_state, w_state_nxt;

    logic [31:0] r_ram [64];
    logic [7:0]  r_led;
    logic [31:0] r_cycle;
    logic [31:0] r_load;
    logic [31:0] r_val;
    logic        r_ar;
    logic        r_exp;

    logic [31:0] w_val_nxt;
    logic        w_ar_nxt;
    logic        w_exp_nxt;
    logic        w_expire;

    // ---------------- address decode ----------------
    logic       w_map, w_ram_sel, w_reg_sel;
    logic [5:0] w_idx;
    logic       w_wr_led, w_wr_cycle, w_wr_load, w_wr_ctrl;
    logic       w_unused_ok;

    assign w_map     = (Adr[31:9] == 23'd0);
    assign w_ram_sel = w_map & ~Adr[8];
    assign w_reg_sel = w_map &  Adr[8];
    assign w_idx     = Adr[7:2];

    assign w_wr_led   = MemWrite & w_reg_sel & (w_idx == 6'd0);
    assign w_wr_cycle = MemWrite & w_reg_sel & (w_idx == 6'd1);
    assign w_wr_load  = MemWrite & w_reg_sel & (w_idx == 6'd2);
    assign w_wr_ctrl  = MemWrite & w_reg_sel & (w_idx == 6'd3);

    assign w_unused_ok = &{1'b0, Adr[1:0]};

    // ---------------- read mux ----------------
    always_comb begin
        ReadData = 32'd0;
        if (w_ram_sel) begin
            ReadData = r_ram[w_idx];
        end else if (w_reg_sel) begin
            case (w_idx)
                6'd0:    ReadData = {24'd0, r_led};
                6'd1:    ReadData = r_cycle;
                6'd2:    ReadData = r_load;
                6'd3:    ReadData = {29'd0, r_exp, r_ar, (r_state == S_RUN)};
                6'd4:    ReadData = r_val;
                default: ReadData = 32'd0;
            endcase
        end
    end

    // ---------------- timer next state ----------------
    // A CTRL write owns state/VAL/AR for that edge. Expiry is detected from
    // the pre-edge state, so EXP still records an expiry that coincides with
    // a CTRL write, and beats a write-1-to-clear in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_val_nxt   = r_val;
        w_ar_nxt    = r_ar;
        w_expire    = (r_state == S_RUN) && (r_val == 32'd0);

        if (w_wr_ctrl) begin
            w_ar_nxt = WriteData[1];
            if (WriteData[0]) begin
                w_state_nxt = S_RUN;
                w_val_nxt   = r_load;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else if (r_state == S_RUN) begin
            if (r_val != 32'd0) begin
                w_val_nxt = r_val - 32'd1;
            end else if (r_ar) begin
                w_val_nxt = r_load;
            end else begin
                w_state_nxt = S_EXPIRED;
            end
        end

        if (w_expire)
            w_exp_nxt = 1'b1;
        else if (w_wr_ctrl && WriteData[2])
            w_exp_nxt = 1'b0;
        else
            w_exp_nxt = r_exp;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_led   <= 8'd0;
            r_cycle <= 32'd0;
            r_load  <= 32'd0;
            r_val   <= 32'd0;
            r_ar    <= 1'b0;
            r_exp   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_val   <= w_val_nxt;
            r_ar    <= w_ar_nxt;
            r_exp   <= w_exp_nxt;
            r_cycle <= w_wr_cycle ? 32'd0 : r_cycle + 32'd1;
            if (w_wr_led)
                r_led <= WriteData[7:0];
            if (w_wr_load)
                r_load <= WriteData;
        end
    end

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (MemWrite && w_ram_sel)
            r_ram[w_idx] <= WriteData;
    end

    assign LedOut    = r_led;
    assign TimerFlag = r_exp;

endmodule
